rs_chien_forney_p: RTL and testbench

Parametrised Chien search and Forney evaluator for the RS decoder back end. It runs after the key-equation solver and before the error-correction XOR stage. It accepts the error-locator Λ(x) and error-evaluator Ω(x) in one parallel load, computes the divisor inverse internally, and supports any symbol width, correction capability, first consecutive root and shortened length. Output is a registered stream of one error magnitude per codeword position, plus a root count and a decode-fail flag.

---
 rtl/rs_chien_forney_p_if.sv | 34 +++
 rtl/rs_chien_forney_p.sv | 211 +++++++++++++++++++++
 tb/tb_rs_chien_forney_p.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rs_chien_forney_p_if.sv
// Parallel load of Λ/Ω into the Chien/Forney block and the per-position
// error-magnitude stream it returns.
interface rs_chien_forney_p_if #(
    parameter int M = 8,
    parameter int T = 6,
    parameter int N = 255
);
    localparam int PW = $clog2(N);
    localparam int CW = $clog2(T + 1) + 1;

    // start is taken only on a cycle where ready=1; the stream side has no
    // backpressure, so the consumer must accept every out_valid beat.
    logic                 start;
    logic                 ready;
    logic [(T+1)*M-1:0]   lambda_in;
    logic [T*M-1:0]       omega_in;
    logic                 out_valid;
    logic [PW-1:0]        err_pos;
    logic                 err_root;
    logic [M-1:0]         err_val;
    logic                 done;
    logic [CW-1:0]        err_cnt;
    logic                 fail;

    modport master (
        output start, lambda_in, omega_in,
        input  ready, out_valid, err_pos, err_root, err_val, done, err_cnt, fail
    );

    modport slave (
        input  start, lambda_in, omega_in,
        output ready, out_valid, err_pos, err_root, err_val, done, err_cnt, fail
    );
endinterface

// File: rtl/rs_chien_forney_p.sv
// Chien search over all codeword positions with an in-line Forney evaluator;
// emits one registered error magnitude per position, N-1 down to 0.
module rs_chien_forney_p #(
    parameter int         M    = 8,
    parameter logic [M:0] POLY = 9'h187,
    parameter int         T    = 6,
    parameter int         N    = 255,
    parameter int         FCR  = 0
) (
    input  logic               clk,
    input  logic               rst,
    rs_chien_forney_p_if.slave bus,
    output logic [1:0]         o_dbg_state
);
    localparam int SHORT = (1 << M) - 1 - N;
    localparam int PW    = $clog2(N);
    localparam int CW    = $clog2(T + 1) + 1;
    localparam int LW    = (T + 1) * M;
    localparam int OW    = T * M;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SKIP   = 2'd1,
        S_SEARCH = 2'd2
    } state_t;

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] acc;
        logic [M-1:0] sh;
        acc = '0;
        sh  = a;
        for (int k = 0; k < M; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = sh[M-1] ? ((sh << 1) ^ POLY[M-1:0]) : (sh << 1);
        end
        return acc;
    endfunction

    function automatic logic [M-1:0] gf_apow(input int e);
        logic [M-1:0] r;
        r = M'(1);
        for (int k = 0; k < e; k++) r = gf_mul(r, M'(2));
        return r;
    endfunction

    // x^(2^M-2) = prod_{k=1..M-1} x^(2^k); a zero input collapses to zero.
    function automatic logic [M-1:0] gf_inv(input logic [M-1:0] x);
        logic [M-1:0] sq;
        logic [M-1:0] r;
        sq = x;
        r  = M'(1);
        for (int k = 1; k < M; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    localparam logic [M-1:0] C_ALPHA  = gf_apow(1);
    localparam logic [M-1:0] C_X_INIT = gf_apow(SHORT + 1);

    state_t          r_state;
    logic            r_ready;
    logic [M-1:0]    r_ctr;
    logic [M-1:0]    r_x;
    logic [CW-1:0]   r_deg;
    logic [CW-1:0]   r_cnt;
    logic            r_fail;
    logic            r_ov;
    logic [PW-1:0]   r_pos;
    logic            r_root;
    logic [M-1:0]    r_val;
    logic            r_done;
    logic [LW-1:0]   r_lam;
    logic [OW-1:0]   r_om;

    logic            w_load;
    logic            w_step;
    logic [LW-1:0]   w_lam_src;
    logic [LW-1:0]   w_lam_mul;
    logic [OW-1:0]   w_om_src;
    logic [OW-1:0]   w_om_mul;
    logic [M-1:0]    w_even;
    logic [M-1:0]    w_odd;
    logic [M-1:0]    w_om_sum;
    logic [M-1:0]    w_num;
    logic [M-1:0]    w_val;
    logic            w_root;
    logic [CW-1:0]   w_deg;
    logic [CW-1:0]   w_cnt_next;

    assign w_load    = (r_state == S_IDLE) && r_ready && bus.start;
    assign w_step    = (r_state != S_IDLE);
    assign w_lam_src = w_load ? bus.lambda_in : r_lam;
    assign w_om_src  = w_load ? bus.omega_in  : r_om;

    // One constant α^i scaler per coefficient serves both the load and every step.
    for (genvar gi = 0; gi <= T; gi++) begin : g_scale
        localparam logic [M-1:0] C_ALPHA_I = gf_apow(gi);
        assign w_lam_mul[gi*M +: M] = gf_mul(w_lam_src[gi*M +: M], C_ALPHA_I);
        if (gi < T) begin : g_om
            assign w_om_mul[gi*M +: M] = gf_mul(w_om_src[gi*M +: M], C_ALPHA_I);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lam <= '0;
            r_om  <= '0;
        end else if (w_load || w_step) begin
            r_lam <= w_lam_mul;
            r_om  <= w_om_mul;
        end
    end

    always_comb begin
        w_even   = '0;
        w_odd    = '0;
        w_om_sum = '0;
        w_deg    = '0;
        for (int i = 0; i <= T; i++) begin
            if (i % 2 == 0) w_even = w_even ^ r_lam[i*M +: M];
            else            w_odd  = w_odd  ^ r_lam[i*M +: M];
            if (bus.lambda_in[i*M +: M] != '0) w_deg = CW'(i);
        end
        for (int i = 0; i < T; i++) w_om_sum = w_om_sum ^ r_om[i*M +: M];
    end

    // Odd part equals x·Λ'(x); with FCR=1 the extra x moves into the numerator.
    assign w_num      = (FCR == 1) ? gf_mul(w_om_sum, r_x) : w_om_sum;
    assign w_root     = (w_even == w_odd);
    assign w_val      = w_root ? gf_mul(w_num, gf_inv(w_odd)) : '0;
    assign w_cnt_next = r_cnt + {{(CW-1){1'b0}}, w_root};

    // Leaving SEARCH lands in IDLE with ready still low for the done cycle;
    // ready rises on the following edge, so a start beside done is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_ctr   <= '0;
            r_x     <= '0;
            r_deg   <= '0;
            r_cnt   <= '0;
            r_fail  <= 1'b0;
            r_ov    <= 1'b0;
            r_pos   <= '0;
            r_root  <= 1'b0;
            r_val   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_ov   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_ready) begin
                        r_ready <= 1'b1;
                    end else if (bus.start) begin
                        r_ready <= 1'b0;
                        r_deg   <= w_deg;
                        r_cnt   <= '0;
                        r_fail  <= 1'b0;
                        r_x     <= C_X_INIT;
                        if (SHORT > 0) begin
                            r_state <= S_SKIP;
                            r_ctr   <= M'(SHORT - 1);
                        end else begin
                            r_state <= S_SEARCH;
                            r_ctr   <= M'(N - 1);
                        end
                    end
                end
                S_SKIP: begin
                    if (r_ctr == '0) begin
                        r_state <= S_SEARCH;
                        r_ctr   <= M'(N - 1);
                    end else begin
                        r_ctr <= r_ctr - 1'b1;
                    end
                end
                S_SEARCH: begin
                    r_ov   <= 1'b1;
                    r_pos  <= r_ctr[PW-1:0];
                    r_root <= w_root;
                    r_val  <= w_val;
                    r_x    <= gf_mul(r_x, C_ALPHA);
                    r_cnt  <= w_cnt_next;
                    r_fail <= r_fail | (w_root & (w_odd == '0))
                            | ((r_ctr == '0) & (w_cnt_next != r_deg));
                    if (r_ctr == '0) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ctr <= r_ctr - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready     = r_ready;
    assign bus.out_valid = r_ov;
    assign bus.err_pos   = r_pos;
    assign bus.err_root  = r_root;
    assign bus.err_val   = r_val;
    assign bus.done      = r_done;
    assign bus.err_cnt   = r_cnt;
    assign bus.fail      = r_fail;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_rs_chien_forney_p.sv
// Bench for rs_chien_forney_p: a full-length FCR=0 instance and a shortened
// FCR=1 instance, checked against a log/antilog-table reference model.
module tb_rs_chien_forney_p;
  localparam int M = 8;
  localparam int T = 6;
  localparam int NV = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rs_chien_forney_p_if #(.M(M), .T(T), .N(255)) b0();
  rs_chien_forney_p_if #(.M(M), .T(T), .N(204)) b1();
  logic [1:0] dbg0, dbg1;

  rs_chien_forney_p #(.M(M), .POLY(9'h187), .T(T), .N(255), .FCR(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0.slave), .o_dbg_state(dbg0));
  rs_chien_forney_p #(.M(M), .POLY(9'h187), .T(T), .N(204), .FCR(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1.slave), .o_dbg_state(dbg1));

  // ---------------- stimulus drivers and output mux ----------------
  logic sel = 1'b0;
  logic start_drv = 1'b0;
  logic [7:0] lam [0:T];
  logic [7:0] om [0:T-1];
  logic [(T+1)*M-1:0] lam_bus;
  logic [T*M-1:0] om_bus;

  always_comb begin
    lam_bus = '0;
    om_bus = '0;
    for (int i = 0; i <= T; i++) lam_bus[i*M +: M] = lam[i];
    for (int i = 0; i < T; i++) om_bus[i*M +: M] = om[i];
  end

  assign b0.start = start_drv & ~sel;
  assign b1.start = start_drv & sel;
  assign b0.lambda_in = lam_bus;
  assign b1.lambda_in = lam_bus;
  assign b0.omega_in = om_bus;
  assign b1.omega_in = om_bus;

  logic ready_m, ov_m, root_m, done_m, fail_m;
  logic [7:0] pos_m, val_m;
  logic [3:0] cnt_m;
  logic [1:0] dbg_m;

  always_comb begin
    if (sel) begin
      ready_m = b1.ready; ov_m = b1.out_valid; root_m = b1.err_root; done_m = b1.done;
      fail_m = b1.fail; pos_m = b1.err_pos; val_m = b1.err_val; cnt_m = b1.err_cnt; dbg_m = dbg1;
    end else begin
      ready_m = b0.ready; ov_m = b0.out_valid; root_m = b0.err_root; done_m = b0.done;
      fail_m = b0.fail; pos_m = b0.err_pos; val_m = b0.err_val; cnt_m = b0.err_cnt; dbg_m = dbg0;
    end
  end

  // ---------------- scoreboard state ----------------
  int n_pass = 0;
  int n_total = 0;
  logic [17:0] exp_q[$];
  int exp_cnt;
  logic exp_fail;
  logic [7:0] cap_val [0:255];
  logic cap_root [0:255];
  logic [3:0] cap_cnt;
  logic cap_fail;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
  endtask

  // ---------------- reference model (log/antilog GF arithmetic) ----------------
  logic [7:0] exp_t [0:254];
  int log_t [0:255];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 0 || b == 0) return 8'h00;
    return exp_t[(log_t[a] + log_t[b]) % 255];
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    if (a == 0) return 8'h00;
    return exp_t[(255 - log_t[a]) % 255];
  endfunction

  task automatic build_tables();
    logic [8:0] v;
    v = 9'h001;
    for (int e = 0; e < 255; e++) begin
      exp_t[e] = v[7:0];
      log_t[v[7:0]] = e;
      v = v << 1;
      if (v[8]) v = v ^ 9'h187;
    end
  endtask

  // Position p is in error when Λ(α^-p)=0; magnitude = x^FCR·Ω(x) / (x·Λ'(x)).
  task automatic build_model(input int n, input int fcr);
    int cnt, deg;
    logic f, root;
    logic [7:0] x, xp, t, lv, odd_v, ov, num, val, p8;
    exp_q.delete();
    deg = 0;
    for (int i = 0; i <= T; i++) if (lam[i] != 0) deg = i;
    cnt = 0;
    f = 1'b0;
    for (int p = n - 1; p >= 0; p--) begin
      x = exp_t[(255 - p) % 255];
      xp = 8'h01; lv = 0; odd_v = 0; ov = 0;
      for (int i = 0; i <= T; i++) begin
        t = gmul(lam[i], xp);
        lv = lv ^ t;
        if (i % 2 == 1) odd_v = odd_v ^ t;
        if (i < T) ov = ov ^ gmul(om[i], xp);
        xp = gmul(xp, x);
      end
      root = (lv == 0);
      num = (fcr == 1) ? gmul(ov, x) : ov;
      val = root ? gmul(num, ginv(odd_v)) : 8'h00;
      if (root) begin
        cnt++;
        if (odd_v == 0) f = 1'b1;
      end
      p8 = p[7:0];
      exp_q.push_back({p8, root, val, (p == 0)});
    end
    if (cnt != deg) f = 1'b1;
    exp_cnt = cnt;
    exp_fail = f;
  endtask

  // ---------------- driver: one full codeword ----------------
  // poke=1: extra start at cycle 50; poke=2: extra start during the done cycle.
  task automatic run_case(input logic s, input int poke);
    int n, sh, got, k, last, w;
    logic [17:0] e, a;
    n = s ? 204 : 255;
    sh = 255 - n;
    last = sh + n + 1;
    sel = s;
    build_model(n, s ? 1 : 0);
    for (int i = 0; i < 256; i++) begin cap_val[i] = 8'h00; cap_root[i] = 1'b0; end
    @(negedge clk);
    w = 0;
    while (!ready_m && w < 20) begin @(negedge clk); w++; end
    check("ready_before_start", ready_m, 1);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    got = 0;
    for (k = 1; k <= last + 5 && got < n; k++) begin
      if (k > 1) @(negedge clk);
      if (poke == 1) start_drv = (k == 50);
      if (ov_m) begin
        if (got == 0) check("first_valid_cycle", k, sh + 2);
        e = exp_q.pop_front();
        a = {pos_m, root_m, val_m, done_m};
        check($sformatf("stream_pos%0d", e[17:10]), a, e);
        cap_val[pos_m] = val_m;
        cap_root[pos_m] = root_m;
        got++;
        if (got == n) begin
          check("done_cycle", k, last);
          check("ready_low_at_done", ready_m, 0);
          check("err_cnt_model", cnt_m, exp_cnt);
          check("fail_model", fail_m, exp_fail);
          cap_cnt = cnt_m;
          cap_fail = fail_m;
          if (poke == 2) start_drv = 1'b1;
        end
      end
    end
    if (got < n) check("stream_timeout", got, n);
    @(negedge clk);
    start_drv = 1'b0;
    check("ready_after_done", ready_m, 1);
    check("valid_after_done", ov_m, 0);
    if (poke == 2) begin
      @(negedge clk);
      check("start_at_done_ignored", {ready_m, dbg_m}, {1'b1, 2'b00});
    end
  endtask

  task automatic load_s0();
    for (int i = 0; i <= T; i++) lam[i] = 8'h00;
    for (int i = 0; i < T; i++) om[i] = 8'h00;
    lam[0] = 8'h01; lam[1] = 8'h01; om[0] = 8'h01;
  endtask

  // ---------------- directed table ----------------
  typedef struct packed {
    logic        s;
    logic [55:0] l;
    logic [47:0] o;
    logic [3:0]  cnt;
    logic        fl;
    logic        has_root;
    logic [7:0]  rpos;
    logic [7:0]  rval;
  } vec_t;
  vec_t tbl [0:NV-1];

  task automatic set_vec(input int idx, input logic s, input logic [55:0] l, input logic [47:0] o,
                         input logic [3:0] cnt, input logic fl, input logic hr,
                         input logic [7:0] rpos, input logic [7:0] rval);
    tbl[idx].s = s; tbl[idx].l = l; tbl[idx].o = o; tbl[idx].cnt = cnt;
    tbl[idx].fl = fl; tbl[idx].has_root = hr; tbl[idx].rpos = rpos; tbl[idx].rval = rval;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, nerr, q, lim;
    logic used [0:254];
    logic [7:0] a3;
    build_tables();
    load_s0();

    // reset state of both instances
    @(negedge clk);
    sel = 1'b0;
    #1;
    check("reset_u0", {ready_m, ov_m, pos_m, root_m, val_m, done_m, cnt_m, fail_m, dbg_m},
          {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'b00});
    sel = 1'b1;
    #1;
    check("reset_u1", {ready_m, ov_m, pos_m, root_m, val_m, done_m, cnt_m, fail_m, dbg_m},
          {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'b00});
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // {instance, Λ(λ6..λ0), Ω(ω5..ω0), err_cnt, fail, root known, root pos, root value}
    set_vec(0, 1'b0, 56'h0101, 48'h01, 4'd1, 1'b0, 1'b1, 8'd0, 8'h01);
    set_vec(1, 1'b0, 56'h01,   48'h00, 4'd0, 1'b0, 1'b0, 8'd0, 8'h00);
    set_vec(2, 1'b0, 56'h010001, 48'h01, 4'd1, 1'b1, 1'b1, 8'd0, 8'h00);
    set_vec(3, 1'b1, 56'h0101, 48'h01, 4'd1, 1'b0, 1'b1, 8'd0, 8'h01);
    // FCR=1: root x=α^-1 at pos 1, num = x·α² = α, odd = α·x = 1 -> α
    set_vec(4, 1'b1, 56'h0201, 48'h04, 4'd1, 1'b0, 1'b1, 8'd1, 8'h02);
    a3 = exp_t[3] ^ exp_t[10];
    set_vec(5, 1'b0, {32'h0, exp_t[13], a3, 8'h01}, 48'h0305, 4'd2, 1'b0, 1'b0, 8'd0, 8'h00);

    for (int v = 0; v < NV; v++) begin
      for (int i = 0; i <= T; i++) lam[i] = tbl[v].l[i*8 +: 8];
      for (int i = 0; i < T; i++) om[i] = tbl[v].o[i*8 +: 8];
      run_case(tbl[v].s, 0);
      check($sformatf("tbl%0d_err_cnt", v), cap_cnt, tbl[v].cnt);
      check($sformatf("tbl%0d_fail", v), cap_fail, tbl[v].fl);
      if (tbl[v].has_root)
        check($sformatf("tbl%0d_root_val", v), {cap_root[tbl[v].rpos], cap_val[tbl[v].rpos]},
              {1'b1, tbl[v].rval});
    end

    // start while busy is ignored
    load_s0();
    run_case(1'b0, 1);
    check("busy_start_cnt", cap_cnt, 4'd1);

    // start coincident with done is ignored
    load_s0();
    run_case(1'b0, 2);

    // reset in the middle of a search
    load_s0();
    sel = 1'b0;
    @(negedge clk);
    start_drv = 1'b1;
    @(negedge clk);
    start_drv = 1'b0;
    repeat (99) @(negedge clk);
    check("running_before_rst", {ov_m, ready_m}, {1'b1, 1'b0});
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {ready_m, ov_m, pos_m, root_m, val_m, done_m, cnt_m, fail_m, dbg_m},
          {1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 2'b00});
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if (done_m || ov_m) bad++;
    end
    check("quiet_after_rst", bad, 0);
    run_case(1'b0, 0);

    // randomized error patterns
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i <= T; i++) lam[i] = 8'h00;
      for (int i = 0; i < T; i++) om[i] = 8'h00;
      for (int i = 0; i < 255; i++) used[i] = 1'b0;
      lam[0] = 8'h01;
      nerr = $urandom_range(1, T);
      if (r == 5) begin
        for (int i = 1; i <= T; i++) lam[i] = 8'($urandom_range(0, 255));
      end else begin
        lim = (r % 2 == 1) ? 230 : 254;
        for (int j = 0; j < nerr; j++) begin
          q = $urandom_range(0, lim);
          while (used[q]) q = (q + 1) % (lim + 1);
          used[q] = 1'b1;
          for (int i = T; i >= 1; i--) lam[i] = lam[i] ^ gmul(exp_t[q], lam[i-1]);
        end
      end
      for (int i = 0; i < nerr && i < T; i++) om[i] = 8'($urandom_range(0, 255));
      run_case(1'(r % 2), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
